// File: rtl/fxp_mult_if.sv
// Operand/result bus for fxp_mult_pipe.
//
// Handshake: a beat moves on a rising clock edge where valid & ready are both
// high. The source holds valid and its payload stable until that edge and
// never waits for ready before raising valid. ready may depend combinationally
// on the consumer's own state and on the opposite-direction ready.
interface fxp_mult_if #(
    parameter int QLEN  = 16,
    parameter int LANES = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*QLEN-1:0] a;
    logic [LANES*QLEN-1:0] b;
    logic                  rnd_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*QLEN-1:0] res;
    logic [LANES-1:0]      ovf;

    // Operand producer and result consumer side.
    modport master (
        output in_valid, a, b, rnd_mode, out_ready,
        input  in_ready, out_valid, res, ovf
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, rnd_mode, out_ready,
        output in_ready, out_valid, res, ovf
    );
endinterface

// File: rtl/fxp_mult_pipe.sv
// Two-stage pipelined multi-lane signed fixed-point multiplier.
// Stage 1 registers full-width products, stage 2 rounds/truncates and
// narrows to QLEN bits. One global stall enable freezes both stages.
// Optional saturation: define FXP_MULT_SAT_EN to clamp out-of-range results
// and flag them on ovf; otherwise results wrap and ovf stays 0.
// The integer part (QLEN-FRAC_SIZE bits, sign included) follows from
// QLEN and FRAC_SIZE; there is no parameter for it.
module fxp_mult_pipe #(
    parameter int QLEN      = 16,
    parameter int FRAC_SIZE = 12,
    parameter int LANES     = 1
) (
    input logic         clk,
    input logic         rst,
    fxp_mult_if.slave   bus
);
    localparam int PW = 2 * QLEN;
    localparam logic [PW:0] HALF = {{PW{1'b0}}, 1'b1} << (FRAC_SIZE - 1);

    logic                  en;
    logic                  s1_valid;
    logic                  s1_rnd;
    logic signed [PW-1:0]  s1_prod [LANES];
    logic                  out_valid_q;
    logic [LANES*QLEN-1:0] res_q;
    logic [LANES-1:0]      ovf_q;
    logic [LANES*QLEN-1:0] res_next;
    logic [LANES-1:0]      ovf_next;

    // Whole pipe advances unless a held result is waiting on the consumer.
    assign en           = bus.out_ready | ~out_valid_q;
    assign bus.in_ready = en;
    assign bus.out_valid = out_valid_q;
    assign bus.res      = res_q;
    assign bus.ovf      = ovf_q;

    // Stage 1: capture full-precision products and the beat's rounding mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_rnd   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
            end
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_rnd   <= bus.rnd_mode;
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= $signed(bus.a[i*QLEN +: QLEN]) * $signed(bus.b[i*QLEN +: QLEN]);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // One extra bit on the rounding sum so adding the half-LSB can never wrap.
        logic signed [PW:0]   rsum;
        logic signed [PW:0]   q;
        logic [QLEN-1:0]      r;
        logic                 o;

        assign rsum = {s1_prod[i][PW-1], s1_prod[i]} + (s1_rnd ? HALF : '0);
        // Arithmetic shift floors toward -inf, so truncation and half-up share it.
        assign q    = rsum >>> FRAC_SIZE;

`ifdef FXP_MULT_SAT_EN
        logic in_win;
        // q fits QLEN signed bits when every bit from QLEN-1 upward equals the sign.
        assign in_win = (&q[PW:QLEN-1]) | ~(|q[PW:QLEN-1]);

        // Clamp to the nearest representable extreme and flag the lane.
        always_comb begin
            r = q[QLEN-1:0];
            o = 1'b0;
            if (!in_win) begin
                r = q[PW] ? {1'b1, {(QLEN-1){1'b0}}} : {1'b0, {(QLEN-1){1'b1}}};
                o = 1'b1;
            end
        end
`else
        logic unused_hi;
        assign unused_hi = ^q[PW:QLEN];

        // Wrap: keep the low QLEN bits, no overflow reporting.
        always_comb begin
            r = q[QLEN-1:0];
            o = 1'b0;
        end
`endif

        assign res_next[i*QLEN +: QLEN] = r;
        assign ovf_next[i]              = o;
    end

    // Stage 2: register the narrowed result; payload only changes with a valid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= '0;
        end else if (en) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                res_q <= res_next;
                ovf_q <= ovf_next;
            end
        end
    end
endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Self-checking bench for fxp_mult_pipe (QLEN=16, FRAC_SIZE=12, LANES=2).
// Build with or without FXP_MULT_SAT_EN; the reference model follows the macro.
module tb_fxp_mult_pipe;
    localparam int QLEN  = 16;
    localparam int FRAC  = 12;
    localparam int LANES = 2;
    localparam int W     = LANES * QLEN;
    localparam int EW    = W + LANES;
    localparam longint MAXV = (longint'(1) <<< (QLEN - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (QLEN - 1));

    logic clk;
    logic rst;

    fxp_mult_if #(.QLEN(QLEN), .LANES(LANES)) bus ();

    fxp_mult_pipe #(.QLEN(QLEN), .FRAC_SIZE(FRAC), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    bit done;
    logic [EW-1:0] exp_q[$];

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Plain integer arithmetic: exact product, optional half-LSB, floor divide.
    function automatic logic [EW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic r);
        logic [W-1:0]     rv;
        logic [LANES-1:0] ov;
        longint           p;
        longint           q;
        rv = '0;
        ov = '0;
        for (int i = 0; i < LANES; i++) begin
            p = longint'($signed(av[i*QLEN +: QLEN])) * longint'($signed(bv[i*QLEN +: QLEN]));
            if (r) p = p + (longint'(1) <<< (FRAC - 1));
            q = p >>> FRAC;
`ifdef FXP_MULT_SAT_EN
            if (q > MAXV) begin
                rv[i*QLEN +: QLEN] = QLEN'(MAXV);
                ov[i] = 1'b1;
            end else if (q < MINV) begin
                rv[i*QLEN +: QLEN] = QLEN'(MINV);
                ov[i] = 1'b1;
            end else begin
                rv[i*QLEN +: QLEN] = QLEN'(q);
            end
`else
            rv[i*QLEN +: QLEN] = QLEN'(q);
`endif
        end
        return {rv, ov};
    endfunction

    function automatic logic [QLEN-1:0] rand_word();
        logic [QLEN-1:0] corners [6];
        corners = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000, 16'h1000};
        case ($urandom_range(0, 3))
            0, 1:    return QLEN'($urandom);
            2:       return QLEN'($urandom_range(0, 1023)) - 16'd512;
            default: return corners[$urandom_range(0, 5)];
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    task automatic monitor();
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    out_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL sb_unexpected: res=%h ovf=%b with no beat outstanding",
                                 bus.res, bus.ovf);
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus.res, bus.ovf} !== e)
                            $display("FAIL sb_result: got res=%h ovf=%b want res=%h ovf=%b",
                                     bus.res, bus.ovf, e[EW-1:LANES], e[LANES-1:0]);
                        else
                            passes++;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(model(bus.a, bus.b, bus.rnd_mode));
                    acc_cnt++;
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [W-1:0] av, input logic [W-1:0] bv, input logic r);
        bit acc;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.rnd_mode = r;
        do begin
            @(posedge clk);
            acc = bus.in_ready;
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout: in_ready=0 for %0d cycles, want accept", n);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One beat in, result sampled exactly two edges after it was presented.
    task automatic run_one(input logic [W-1:0] av, input logic [W-1:0] bv, input logic r,
                           output logic v, output logic [W-1:0] rs, output logic [LANES-1:0] o);
        send_beat(av, bv, r);
        @(posedge clk);
        #1;
        v  = bus.out_valid;
        rs = bus.res;
        o  = bus.ovf;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        else passes++;
        checks++;
        if (bus.res !== '0) $display("FAIL reset_res: got %h want 0", bus.res);
        else passes++;
        checks++;
        if (bus.ovf !== '0) $display("FAIL reset_ovf: got %b want 0", bus.ovf);
        else passes++;
        checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else passes++;
    endtask

    task automatic test_latency();
        idle();
        send_beat({16'h0800, 16'h1800}, {16'h2000, 16'h2000}, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL latency_early: out_valid got %b want 0", bus.out_valid);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1) $display("FAIL latency_valid: out_valid got %b want 1", bus.out_valid);
        else passes++;
        checks++;
        if (bus.res !== {16'h1000, 16'h3000}) $display("FAIL latency_res: got %h want 10003000", bus.res);
        else passes++;
        checks++;
        if (bus.ovf !== 2'b00) $display("FAIL latency_ovf: got %b want 00", bus.ovf);
        else passes++;
    endtask

    task automatic test_rounding();
        logic v;
        logic [W-1:0] rs;
        logic [LANES-1:0] o;
        idle();
        // lane0: +0.5 LSB tie, lane1: -0.5 LSB tie
        run_one({16'hFFFF, 16'h0001}, {16'h0800, 16'h0800}, 1'b0, v, rs, o);
        checks++;
        if (!v || rs !== {16'hFFFF, 16'h0000})
            $display("FAIL round_trunc: valid=%b res=%h want valid=1 res=ffff0000", v, rs);
        else passes++;
        run_one({16'hFFFF, 16'h0001}, {16'h0800, 16'h0800}, 1'b1, v, rs, o);
        checks++;
        if (!v || rs !== {16'h0000, 16'h0001})
            $display("FAIL round_halfup: valid=%b res=%h want valid=1 res=00000001", v, rs);
        else passes++;
    endtask

    task automatic test_overflow();
        logic v;
        logic [W-1:0] rs;
        logic [LANES-1:0] o;
        logic [W-1:0] want_r1;
        logic [W-1:0] want_r2;
        logic [LANES-1:0] want_o1;
        logic [LANES-1:0] want_o2;
`ifdef FXP_MULT_SAT_EN
        want_r1 = {16'h8000, 16'h7FFF};
        want_o1 = 2'b11;
        want_r2 = {16'h3000, 16'h7FFF};
        want_o2 = 2'b01;
`else
        want_r1 = {16'h2000, 16'hE000};
        want_o1 = 2'b00;
        want_r2 = {16'h3000, 16'hE000};
        want_o2 = 2'b00;
`endif
        idle();
        run_one({16'h9000, 16'h7000}, {16'h2000, 16'h2000}, 1'b0, v, rs, o);
        checks++;
        if (!v || rs !== want_r1 || o !== want_o1)
            $display("FAIL ovf_both: valid=%b res=%h ovf=%b want res=%h ovf=%b", v, rs, o, want_r1, want_o1);
        else passes++;
        // Only lane 0 overflows: lanes must not influence each other.
        run_one({16'h1800, 16'h7000}, {16'h2000, 16'h2000}, 1'b1, v, rs, o);
        checks++;
        if (!v || rs !== want_r2 || o !== want_o2)
            $display("FAIL ovf_lane0: valid=%b res=%h ovf=%b want res=%h ovf=%b", v, rs, o, want_r2, want_o2);
        else passes++;
    endtask

    task automatic test_backpressure();
        int base_acc;
        int base_out;
        int n;
        logic [W-1:0] held;
        idle();
        base_acc = acc_cnt;
        base_out = out_cnt;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send_beat({rand_word(), rand_word()}, {rand_word(), rand_word()},
                              1'($urandom_range(0, 1)));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                held = bus.res;
                repeat (4) @(posedge clk);
                #1;
                checks++;
                if (acc_cnt - base_acc != 2)
                    $display("FAIL bp_accepted: got %0d beats want 2", acc_cnt - base_acc);
                else passes++;
                checks++;
                if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", bus.in_ready);
                else passes++;
                checks++;
                if (bus.out_valid !== 1'b1 || bus.res !== held)
                    $display("FAIL bp_hold: valid=%b res=%h want valid=1 res=%h", bus.out_valid, bus.res, held);
                else passes++;
                bus.out_ready = 1'b1;
            end
        join
        n = 0;
        while (out_cnt - base_out < 5 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_cnt - base_out != 5 || exp_q.size() != 0)
            $display("FAIL bp_drain: got %0d results (%0d pending) want 5 (0 pending)",
                     out_cnt - base_out, exp_q.size());
        else passes++;
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup: out_valid got %b want 0", bus.out_valid);
        else passes++;
    endtask

    task automatic test_random();
        int base_acc;
        int base_out;
        int n;
        idle();
        base_acc = acc_cnt;
        base_out = out_cnt;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send_beat({rand_word(), rand_word()}, {rand_word(), rand_word()},
                              1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0 || (out_cnt - base_out) != (acc_cnt - base_acc) || acc_cnt - base_acc != 300)
            $display("FAIL rand_drain: accepted=%0d emitted=%0d pending=%0d want 300/300/0",
                     acc_cnt - base_acc, out_cnt - base_out, exp_q.size());
        else passes++;
    endtask

    task automatic test_reset_inflight();
        int base_out;
        idle();
        bus.out_ready = 1'b0;
        send_beat({16'h1800, 16'h1800}, {16'h2000, 16'h2000}, 1'b0);
        send_beat({16'h0800, 16'h0800}, {16'h2000, 16'h2000}, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.res !== '0 || bus.ovf !== '0)
            $display("FAIL rst_async: valid=%b res=%h ovf=%b want 0/0/0", bus.out_valid, bus.res, bus.ovf);
        else passes++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        base_out = out_cnt;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_cnt != base_out || bus.out_valid !== 1'b0)
            $display("FAIL rst_stale: %0d beats emitted after release, out_valid=%b want 0",
                     out_cnt - base_out, bus.out_valid);
        else passes++;
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.rnd_mode  = 1'b0;
        bus.out_ready = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        test_reset();
        test_latency();
        test_rounding();
        test_overflow();
        test_backpressure();
        test_random();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
